ram_wr_sched: RTL and testbench

Write-port scheduler for the 256×9 synchronous write-only RAM wrapper. It shares the RAM's single write port between two requesters using round-robin arbitration with a valid/ready handshake. It owns the clear-memory sweep: every address is written with `INIT_VAL` after reset and on request. It sits directly in front of the RAM, and its `mem_*` outputs connect one-to-one to the RAM write port.

---
 rtl/ram_wr_sched.sv | 107 ++++++++++
 tb/tb_ram_wr_sched.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_wr_sched.sv
// Write-port scheduler for the 256x9 write-only RAM: round-robin arbitration of two
// valid/ready requesters plus a clear-memory sweep after reset and on init_start.
module ram_wr_sched #(
    parameter int unsigned          AW       = 8,
    parameter int unsigned          DW       = 9,
    parameter int unsigned          DEPTH    = 256,
    parameter logic [DW-1:0]        INIT_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init_start,
    output logic          init_busy,
    input  logic          r0_valid,
    output logic          r0_ready,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_data,
    input  logic          r1_valid,
    output logic          r1_ready,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_data,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_di,
    output logic          last_grant,
    output logic [15:0]   wr_count
);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] sweep_ptr;
    logic          sweep_last;

    assign sweep_last = (sweep_ptr == AW'(DEPTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // init_start in S_RUN suppresses both grants so the sweep wins any pending request
    always_comb begin
        state_nxt = state;
        init_busy = 1'b0;
        r0_ready  = 1'b0;
        r1_ready  = 1'b0;
        case (state)
            S_INIT: begin
                init_busy = 1'b1;
                if (sweep_last) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (init_start) begin
                    state_nxt = S_INIT;
                end else begin
                    r0_ready = r0_valid && (!r1_valid || last_grant);
                    r1_ready = r1_valid && (!r0_valid || !last_grant);
                end
            end
            default: state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sweep_ptr  <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_di     <= '0;
            last_grant <= 1'b1;
            wr_count   <= '0;
        end else if (state == S_INIT) begin
            mem_we    <= 1'b1;
            mem_addr  <= sweep_ptr;
            mem_di    <= INIT_VAL;
            sweep_ptr <= sweep_last ? '0 : sweep_ptr + AW'(1);
        end else if (r0_ready) begin
            mem_we     <= 1'b1;
            mem_addr   <= r0_addr;
            mem_di     <= r0_data;
            last_grant <= 1'b0;
            if (wr_count != '1) begin
                wr_count <= wr_count + 16'd1;
            end
        end else if (r1_ready) begin
            mem_we     <= 1'b1;
            mem_addr   <= r1_addr;
            mem_di     <= r1_data;
            last_grant <= 1'b1;
            if (wr_count != '1) begin
                wr_count <= wr_count + 16'd1;
            end
        end else begin
            mem_we <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_wr_sched.sv
// Directed bench for ram_wr_sched: per-cycle vector table for arbitration, plus
// hand-written sequences for sweeps, reset mid-sweep and counter saturation.
module tb_ram_wr_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       init_start = 1'b0;
    logic       init_busy;
    logic       r0_valid = 1'b0;
    logic       r0_ready;
    logic [7:0] r0_addr = 8'h00;
    logic [8:0] r0_data = 9'h000;
    logic       r1_valid = 1'b0;
    logic       r1_ready;
    logic [7:0] r1_addr = 8'h00;
    logic [8:0] r1_data = 9'h000;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [8:0] mem_di;
    logic       last_grant;
    logic [15:0] wr_count;

    int n_checks = 0;
    int n_errors = 0;

    ram_wr_sched #(
        .AW(8),
        .DW(9),
        .DEPTH(256),
        .INIT_VAL(9'h000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .init_start(init_start),
        .init_busy(init_busy),
        .r0_valid(r0_valid),
        .r0_ready(r0_ready),
        .r0_addr(r0_addr),
        .r0_data(r0_data),
        .r1_valid(r1_valid),
        .r1_ready(r1_ready),
        .r1_addr(r1_addr),
        .r1_data(r1_data),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_di(mem_di),
        .last_grant(last_grant),
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is;
        logic        r0v;
        logic [7:0]  r0a;
        logic [8:0]  r0d;
        logic        r1v;
        logic [7:0]  r1a;
        logic [8:0]  r1d;
        logic        e_rdy0;
        logic        e_rdy1;
        logic        e_we;
        logic [7:0]  e_addr;
        logic [8:0]  e_di;
        logic        e_lg;
        logic [15:0] e_cnt;
        logic        e_busy;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered at a falling edge; leaves at the next falling edge.
    task automatic apply(input vec_t v, input string tag);
        init_start = v.is;
        r0_valid = v.r0v; r0_addr = v.r0a; r0_data = v.r0d;
        r1_valid = v.r1v; r1_addr = v.r1a; r1_data = v.r1d;
        #1;
        chk({tag, ".r0_ready"}, 32'(r0_ready), 32'(v.e_rdy0));
        chk({tag, ".r1_ready"}, 32'(r1_ready), 32'(v.e_rdy1));
        @(posedge clk); #1;
        chk({tag, ".mem_we"}, 32'(mem_we), 32'(v.e_we));
        chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(v.e_addr));
        chk({tag, ".mem_di"}, 32'(mem_di), 32'(v.e_di));
        chk({tag, ".last_grant"}, 32'(last_grant), 32'(v.e_lg));
        chk({tag, ".wr_count"}, 32'(wr_count), 32'(v.e_cnt));
        chk({tag, ".init_busy"}, 32'(init_busy), 32'(v.e_busy));
        @(negedge clk);
    endtask

    // Full 256-entry sweep starting at a falling edge; requester inputs left as set by caller.
    task automatic do_sweep(input string tag, input logic [15:0] cnt, input logic lg);
        for (int unsigned k = 0; k < 256; k++) begin
            #1;
            chk({tag, ".rdy0"}, 32'(r0_ready), 32'h0);
            chk({tag, ".rdy1"}, 32'(r1_ready), 32'h0);
            chk({tag, ".busy"}, 32'(init_busy), 32'h1);
            @(posedge clk); #1;
            chk({tag, ".we"}, 32'(mem_we), 32'h1);
            chk({tag, ".addr"}, 32'(mem_addr), k);
            chk({tag, ".di"}, 32'(mem_di), 32'h0);
            chk({tag, ".cnt"}, 32'(wr_count), 32'(cnt));
            chk({tag, ".lg"}, 32'(last_grant), 32'(lg));
            @(negedge clk);
        end
        #1;
        chk({tag, ".busy_done"}, 32'(init_busy), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // contention: r0 10/1AA vs r1 20/055, first tie goes to r0
        tbl[0]  = '{1'b0, 1'b1, 8'h10, 9'h1AA, 1'b1, 8'h20, 9'h055, 1'b1, 1'b0, 1'b1, 8'h10, 9'h1AA, 1'b0, 16'd1, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 8'h10, 9'h1AA, 1'b1, 8'h20, 9'h055, 1'b0, 1'b1, 1'b1, 8'h20, 9'h055, 1'b1, 16'd2, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8'h10, 9'h1AA, 1'b1, 8'h20, 9'h055, 1'b1, 1'b0, 1'b1, 8'h10, 9'h1AA, 1'b0, 16'd3, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 8'h10, 9'h1AA, 1'b1, 8'h20, 9'h055, 1'b0, 1'b1, 1'b1, 8'h20, 9'h055, 1'b1, 16'd4, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 8'h10, 9'h1AA, 1'b1, 8'h20, 9'h055, 1'b1, 1'b0, 1'b1, 8'h10, 9'h1AA, 1'b0, 16'd5, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 8'h10, 9'h1AA, 1'b1, 8'h20, 9'h055, 1'b0, 1'b1, 1'b1, 8'h20, 9'h055, 1'b1, 16'd6, 1'b0};
        // r1 alone with gaps; addresses change while idle but mem_* must hold
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 9'h000, 1'b1, 8'h30, 9'h0F0, 1'b0, 1'b1, 1'b1, 8'h30, 9'h0F0, 1'b1, 16'd7, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 9'h000, 1'b0, 8'h40, 9'h1C3, 1'b0, 1'b0, 1'b0, 8'h30, 9'h0F0, 1'b1, 16'd7, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 9'h000, 1'b1, 8'h41, 9'h101, 1'b0, 1'b1, 1'b1, 8'h41, 9'h101, 1'b1, 16'd8, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 9'h000, 1'b1, 8'h42, 9'h1FF, 1'b0, 1'b1, 1'b1, 8'h42, 9'h1FF, 1'b1, 16'd9, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 9'h000, 1'b0, 8'h77, 9'h033, 1'b0, 1'b0, 1'b0, 8'h42, 9'h1FF, 1'b1, 16'd9, 1'b0};
        // tie after r1 -> r0; then r0 alone after its own grant
        tbl[11] = '{1'b0, 1'b1, 8'h11, 9'h123, 1'b1, 8'h21, 9'h0AB, 1'b1, 1'b0, 1'b1, 8'h11, 9'h123, 1'b0, 16'd10, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 8'h12, 9'h002, 1'b0, 8'h00, 9'h000, 1'b1, 1'b0, 1'b1, 8'h12, 9'h002, 1'b0, 16'd11, 1'b0};
        // init_start collides with r0 request
        tbl[13] = '{1'b1, 1'b1, 8'h13, 9'h1FE, 1'b0, 8'h00, 9'h000, 1'b0, 1'b0, 1'b0, 8'h12, 9'h002, 1'b0, 16'd11, 1'b1};

        // reset state, both requesters already pending
        r0_valid = 1'b1; r0_addr = 8'h10; r0_data = 9'h1AA;
        r1_valid = 1'b1; r1_addr = 8'h20; r1_data = 9'h055;
        #1 rst = 1'b1;
        #2;
        chk("rst.mem_we", 32'(mem_we), 32'h0);
        chk("rst.mem_addr", 32'(mem_addr), 32'h0);
        chk("rst.mem_di", 32'(mem_di), 32'h0);
        chk("rst.last_grant", 32'(last_grant), 32'h1);
        chk("rst.wr_count", 32'(wr_count), 32'h0);
        chk("rst.init_busy", 32'(init_busy), 32'h1);
        chk("rst.r0_ready", 32'(r0_ready), 32'h0);
        chk("rst.r1_ready", 32'(r1_ready), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold.mem_we", 32'(mem_we), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        do_sweep("sweep0", 16'd0, 1'b1);

        for (int unsigned i = 0; i < 14; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // sweep triggered by the collision, r0 still pending throughout
        init_start = 1'b0;
        do_sweep("sweep1", 16'd11, 1'b0);
        apply('{1'b0, 1'b1, 8'h13, 9'h1FE, 1'b0, 8'h00, 9'h000,
                1'b1, 1'b0, 1'b1, 8'h13, 9'h1FE, 1'b0, 16'd12, 1'b0}, "post_init");

        // reset mid-sweep at address 100
        r0_valid = 1'b0;
        apply('{1'b1, 1'b0, 8'h00, 9'h000, 1'b0, 8'h00, 9'h000,
                1'b0, 1'b0, 1'b0, 8'h13, 9'h1FE, 1'b0, 16'd12, 1'b1}, "init2");
        init_start = 1'b0;
        for (int unsigned k = 0; k <= 100; k++) begin
            @(posedge clk); #1;
            chk("part.we", 32'(mem_we), 32'h1);
            chk("part.addr", 32'(mem_addr), k);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk("midrst.mem_we", 32'(mem_we), 32'h0);
        chk("midrst.mem_addr", 32'(mem_addr), 32'h0);
        chk("midrst.wr_count", 32'(wr_count), 32'h0);
        chk("midrst.last_grant", 32'(last_grant), 32'h1);
        chk("midrst.init_busy", 32'(init_busy), 32'h1);
        @(posedge clk); #1;
        chk("midrst_edge.mem_we", 32'(mem_we), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        do_sweep("sweep2", 16'd0, 1'b1);

        // saturation from FFFE
        force dut.wr_count = 16'hFFFE;
        #1;
        release dut.wr_count;
        for (int unsigned i = 0; i < 3; i++) begin
            r1_valid = 1'b1; r1_addr = 8'(8'h50 + i); r1_data = 9'h155;
            #1;
            chk("sat.r1_ready", 32'(r1_ready), 32'h1);
            @(posedge clk); #1;
            chk("sat.mem_we", 32'(mem_we), 32'h1);
            chk("sat.mem_addr", 32'(mem_addr), 32'h50 + i);
            chk("sat.wr_count", 32'(wr_count), 32'hFFFF);
            @(negedge clk);
        end
        r1_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
